// File: rtl/noise_lfsr_voice.sv
// Purpose: LFSR noise voice with long/short taps, rate divider, seed load and amplitude-scaled output.
// Latency: LFSR advances on a divider terminal count; out shows a new LFSR value one cycle after the update.
// Backpressure: none; en freezes the divider and the LFSR, and out keeps tracking amplitude every cycle.
//
// Ports:
//   clk, rst   clock; asynchronous active-high reset
//   en         run the divider and let the LFSR step
//   mode       0 = long taps, 1 = short (127-step) taps
//   period     LFSR steps once every period+1 enabled cycles
//   seed_load  one-cycle strobe that loads seed (0 is loaded as 1)
//   seed       seed value
//   amplitude  output scale; 0 holds out at mid-scale
//   out        registered unsigned noise sample centred on mid-scale
//   step       one-cycle pulse in the cycle after the LFSR advanced
module noise_lfsr_voice #(
    parameter int                LFSR_W    = 15,
    parameter int                OUT_W     = 8,
    parameter int                AMP_W     = 7,
    parameter int                DIV_W     = 16,
    parameter logic [LFSR_W-1:0] SEED      = 15'h0001,
    parameter logic [LFSR_W-1:0] TAP_LONG  = 15'h6000,
    parameter logic [LFSR_W-1:0] TAP_SHORT = 15'h0060
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [DIV_W-1:0]  period,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic [AMP_W-1:0]  amplitude,
    output logic [OUT_W-1:0]  out,
    output logic              step
);

    // Width of the self-contained short-mode register in the low LFSR bits.
    localparam int SHORT_W = 7;
    // Scaling is done at full product width so n*amplitude never wraps.
    localparam int PROD_W = OUT_W + AMP_W;
    localparam logic [PROD_W-1:0] MID     = PROD_W'((1 << (OUT_W - 1)) - 1);
    localparam logic [PROD_W-1:0] AMP_MAX = PROD_W'((1 << AMP_W) - 1);

    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_nxt;
    logic [LFSR_W-1:0] tap;
    logic [LFSR_W-1:0] seed_safe;
    logic [DIV_W-1:0]  div_cnt;
    logic              adv;
    logic              fb;
    logic [PROD_W-1:0] n_w;
    logic [PROD_W-1:0] a_w;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] scaled;

    always_comb begin
        adv = en && (div_cnt == '0);
        tap = mode ? TAP_SHORT : TAP_LONG;
        fb  = ^(lfsr & tap);
        // Short mode runs only on the low bits, which could be all-zero after a
        // long-mode run or a seed with empty low bits; inject a 1 to escape.
        if (mode && (lfsr[SHORT_W-1:0] == '0)) begin
            fb = 1'b1;
        end
        // An all-zero seed would lock the LFSR forever.
        seed_safe = (seed == '0) ? LFSR_W'(1) : seed;

        lfsr_nxt = lfsr;
        if (seed_load) begin
            lfsr_nxt = seed_safe;
        end else if (adv) begin
            lfsr_nxt = {lfsr[LFSR_W-2:0], fb};
        end
    end

    // out = n*amp/AMP_MAX + MID - amp: amp=0 gives MID, amp=max gives n exactly,
    // and the result always stays inside [0, 2^OUT_W-1].
    always_comb begin
        n_w    = PROD_W'(lfsr[LFSR_W-1 -: OUT_W]);
        a_w    = PROD_W'(amplitude);
        prod   = n_w * a_w;
        scaled = prod / AMP_MAX;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr    <= SEED;
            div_cnt <= '0;
            out     <= MID[OUT_W-1:0];
            step    <= 1'b0;
        end else begin
            lfsr <= lfsr_nxt;
            // The divider keeps counting through a seed load; a new period is
            // only picked up at reload.
            if (en) begin
                if (div_cnt == '0) begin
                    div_cnt <= period;
                end else begin
                    div_cnt <= div_cnt - DIV_W'(1);
                end
            end
            step <= adv && !seed_load;
            out  <= OUT_W'(scaled + MID - a_w);
        end
    end

endmodule

// File: tb/tb_noise_lfsr_voice.sv
// Purpose: self-checking bench for noise_lfsr_voice with a step-driven scoreboard.
// Latency: expectations for each step pulse are queued ahead; output values checked at fixed offsets.
// Backpressure: none; the monitor pops one expectation per observed step pulse.
module tb_noise_lfsr_voice;

    logic        clk;
    logic        rst;
    logic        en;
    logic        mode;
    logic [15:0] period;
    logic        seed_load;
    logic [14:0] seed;
    logic [6:0]  amplitude;
    logic [7:0]  out;
    logic        step;

    typedef struct {
        int          gap;     // expected cycles since previous step, 0 = don't check
        bit          chk_l;   // check the LFSR value at this step
        logic [14:0] lfsr;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_chk     = 0;
    int   n_pass    = 0;
    int   cyc       = 0;
    int   last_cyc  = 0;
    bit   mon_on    = 0;
    int   early;

    noise_lfsr_voice dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .period    (period),
        .seed_load (seed_load),
        .seed      (seed),
        .amplitude (amplitude),
        .out       (out),
        .step      (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic push(input int gap, input bit cl, input logic [14:0] l);
        exp_t x;
        x.gap   = gap;
        x.chk_l = cl;
        x.lfsr  = l;
        exp_q.push_back(x);
    endtask

    // Monitor: each step pulse consumes one queued expectation.
    always @(negedge clk) begin
        if (mon_on && step) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_step: step=1 at cycle %0d, expected no step", cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.gap != 0) chk("step_gap", cyc - last_cyc, e.gap);
                if (e.chk_l) chk("step_lfsr", 32'(dut.lfsr), 32'(e.lfsr));
            end
            last_cyc = cyc;
        end
    end

    initial begin
        rst = 1'b0; en = 1'b0; mode = 1'b0; period = 16'd0;
        seed_load = 1'b0; seed = 15'd0; amplitude = 7'd127;
        #1 rst = 1'b1;
        #1;
        chk("reset_out",  out, 127);
        chk("reset_step", step, 0);
        chk("reset_lfsr", 32'(dut.lfsr), 1);
        chk("reset_div",  32'(dut.div_cnt), 0);

        // Long mode, step every cycle: 0x0002,0x0004,...,0x2000,0x4001.
        for (int i = 1; i <= 14; i++) begin
            push((i == 1) ? 0 : 1, 1'b1, (i < 14) ? 15'(1 << i) : 15'h4001);
        end
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b1; mon_on = 1'b1;
        repeat (14) @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk); #1;
        chk("out_full_amp", out, 8'h80);
        chk("step_idle", step, 0);

        // Amplitude scaling with en low.
        amplitude = 7'd0;
        @(posedge clk); #1;
        chk("amp0_mid", out, 127);
        amplitude = 7'd127; seed = 15'h7F80; seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        chk("seedload_nostep", step, 0);
        @(posedge clk); #1;
        chk("amp127_max", out, 255);
        amplitude = 7'd64;
        @(posedge clk); #1;
        chk("amp64", out, 191);
        amplitude = 7'd1;
        @(posedge clk); #1;
        chk("amp1", out, 128);
        amplitude = 7'd127;

        // Divider: period 3 -> spacing 4; en low for 5 cycles -> spacing 9.
        push(0, 1'b0, 15'd0);
        push(4, 1'b0, 15'd0);
        push(4, 1'b0, 15'd0);
        push(9, 1'b0, 15'd0);
        push(4, 1'b0, 15'd0);
        period = 16'd3; en = 1'b1;
        repeat (9) @(posedge clk);
        #1 en = 1'b0;
        repeat (5) @(posedge clk);
        #1 en = 1'b1;
        repeat (8) @(posedge clk);
        #1 en = 1'b0;

        // Zero seed coincident with a step: loads 1, no step pulse.
        period = 16'd0; en = 1'b1;
        push(0, 1'b0, 15'd0);   // step once the old count of 3 drains
        repeat (4) @(posedge clk);
        #1 seed_load = 1'b1; seed = 15'd0;
        @(posedge clk); #1;
        seed_load = 1'b0; en = 1'b0;
        chk("seed0_lfsr", 32'(dut.lfsr), 1);
        chk("seed0_nostep", step, 0);
        mon_on = 1'b0;

        // Short mode: low 7 bits repeat after exactly 127 steps.
        mode = 1'b1; seed = 15'h0001; seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0; en = 1'b1; early = 0;
        for (int i = 1; i <= 127; i++) begin
            @(posedge clk); #1;
            if (i < 127 && dut.lfsr[6:0] == 7'h01) early++;
        end
        en = 1'b0;
        chk("short_period", 32'(dut.lfsr[6:0]), 1);
        chk("short_no_early", early, 0);

        // Long mode: first return to 0x0001 after 32767 steps.
        mode = 1'b0; seed = 15'h0001; seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0; en = 1'b1; early = 0;
        for (int i = 1; i <= 32767; i++) begin
            @(posedge clk); #1;
            if (i < 32767 && dut.lfsr == 15'h0001) early++;
        end
        en = 1'b0;
        chk("long_period", 32'(dut.lfsr), 1);
        chk("long_no_early", early, 0);

        // Asynchronous reset in the middle of a count.
        amplitude = 7'd64;
        @(posedge clk); #1;
        chk("amp64_n0", out, 63);
        period = 16'd100; en = 1'b1;
        @(posedge clk); #3;
        chk("pre_rst_step", step, 1);
        chk("pre_rst_div", 32'(dut.div_cnt), 100);
        rst = 1'b1;
        #1;
        chk("arst_out",  out, 127);
        chk("arst_step", step, 0);
        chk("arst_lfsr", 32'(dut.lfsr), 1);
        chk("arst_div",  32'(dut.div_cnt), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_out",  out, 127);
        chk("rst_hold_step", step, 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
